fibonacci_gen: RTL and testbench

//  Parametrised Fibonacci term generator. Emits one term per step, either
//  one step per f_en rising edge or free-running at a divided tick rate.

---
 rtl/fibonacci_gen.sv | 154 +++++++++++++++
 tb/tb_fibonacci_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fibonacci_gen
//  Description : Parametrised Fibonacci term generator. One term is emitted
//                per step; a step comes either from a rising edge on f_en
//                (step mode) or from a divided tick while f_en is high
//                (free-run mode). Overflow of the WIDTH-bit term either
//                restarts the sequence at F0 (WRAP=1) or halts (WRAP=0).
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                f_en            - step strobe (mode 0) / run enable (mode 1)
//                f_mode          - 0 = step mode, 1 = free-run mode
//                f_clr           - synchronous restart to F0, back to IDLE
//                f_valid         - one-cycle pulse, f_out holds a new term
//                f_out[WIDTH]    - current term, held between steps
//                f_wrap          - pulse with the last term before a wrap
//                f_done          - high while halted (WRAP=0)
//                f_idx[IDX_W]    - index of the term on f_out (FIB_INDEX_EN)
//  Config      : define FIB_INDEX_EN to add the f_idx output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_gen #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 5,
    parameter int WRAP     = 1,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_en,
    input  logic             f_mode,
    input  logic             f_clr,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_out,
    output logic             f_wrap,
    output logic             f_done
`ifdef FIB_INDEX_EN
    ,
    output logic [IDX_W-1:0] f_idx
`endif
);

    localparam int                 c_CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_b_ovf;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_en_q;
    logic [WIDTH-1:0]   r_out;
    logic               r_valid;
    logic               r_wrap;

    logic               w_rise;
    logic               w_run;
    logic               w_tick;
    logic               w_req;
    logic               w_step;
    logic [WIDTH:0]     w_sum;

    assign w_rise = f_en & ~r_en_q;
    assign w_run  = f_en & f_mode;
    assign w_tick = w_run & (r_cnt == c_CNT_LAST);
    assign w_req  = f_mode ? w_tick : w_rise;
    // f_clr wins over a coincident step, and a halted generator ignores steps.
    assign w_step = w_req & (r_state != c_HALT) & ~f_clr;
    // One extra bit so that the carry out of the WIDTH-bit add is kept.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_b_ovf <= 1'b0;
            r_cnt   <= '0;
            // Resets high so an f_en already high through reset is not a rise.
            r_en_q  <= 1'b1;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_en_q  <= f_en;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;

            if (f_clr || !w_run) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (f_clr) begin
                r_state <= c_IDLE;
                r_a     <= '0;
                r_b     <= WIDTH'(1);
                r_b_ovf <= 1'b0;
            end else if (w_step) begin
                r_out   <= r_a;
                r_valid <= 1'b1;
                if (r_b_ovf) begin
                    // r_a is the last representable term; b has already overflowed.
                    if (WRAP != 0) begin
                        r_a     <= '0;
                        r_b     <= WIDTH'(1);
                        r_b_ovf <= 1'b0;
                        r_wrap  <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_HALT;
                    end
                end else begin
                    r_a              <= r_b;
                    {r_b_ovf, r_b}   <= w_sum;
                    r_state          <= c_RUN;
                end
            end
        end
    end

    assign f_out   = r_out;
    assign f_valid = r_valid;
    assign f_wrap  = r_wrap;
    assign f_done  = (r_state == c_HALT);

`ifdef FIB_INDEX_EN
    logic [IDX_W-1:0] r_idx;

    // r_a is zero only when the term about to be emitted is F0 (start or
    // after a wrap), so the index restarts there and counts up otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (f_clr) begin
            r_idx <= '0;
        end else if (w_step) begin
            r_idx <= (r_a == '0) ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign f_idx = r_idx;
`else
    // No index tracking in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fibonacci_gen
//  Description : Directed self-checking bench for fibonacci_gen. Two
//                instances share the stimulus: one with WRAP=1, one with
//                WRAP=0, both WIDTH=16 and TICK_DIV=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci_gen;

    logic        clk;
    logic        rst_n;
    logic        f_en;
    logic        f_mode;
    logic        f_clr;

    logic        valid_w, wrap_w, done_w;
    logic [15:0] out_w;
    logic        valid_h, wrap_h, done_h;
    logic [15:0] out_h;
`ifdef FIB_INDEX_EN
    logic [7:0]  idx_w;
    logic [7:0]  idx_h;
`endif

    int n_total = 0;
    int n_pass  = 0;

    fibonacci_gen #(.WIDTH(16), .TICK_DIV(4), .WRAP(1), .IDX_W(8)) dut_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_en    (f_en),
        .f_mode  (f_mode),
        .f_clr   (f_clr),
        .f_valid (valid_w),
        .f_out   (out_w),
        .f_wrap  (wrap_w),
        .f_done  (done_w)
`ifdef FIB_INDEX_EN
        ,
        .f_idx   (idx_w)
`endif
    );

    fibonacci_gen #(.WIDTH(16), .TICK_DIV(4), .WRAP(0), .IDX_W(8)) dut_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_en    (f_en),
        .f_mode  (f_mode),
        .f_clr   (f_clr),
        .f_valid (valid_h),
        .f_out   (out_h),
        .f_wrap  (wrap_h),
        .f_done  (done_h)
`ifdef FIB_INDEX_EN
        ,
        .f_idx   (idx_h)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq2 [5];
        int fa;
        int fb;
        int tmp;
        int nv;

        seq2 = '{0, 1, 1, 2, 3};
        rst_n  = 1'b0;
        f_en   = 1'b0;
        f_mode = 1'b0;
        f_clr  = 1'b0;
        cyc();
        cyc();
        chk("rst_out",   out_w,   0);
        chk("rst_valid", valid_w, 0);
        chk("rst_wrap",  wrap_w,  0);
        chk("rst_done",  done_h,  0);
        rst_n = 1'b1;
        cyc();

        // 1. step mode: three rises give 0,1,1
        for (int i = 0; i < 3; i++) begin
            f_en = 1'b1;
            cyc();
            chk("t1_valid", valid_w, 1);
            chk("t1_out",   out_w,   (i == 0) ? 0 : 1);
            f_en = 1'b0;
            cyc();
            chk("t1_valid_low", valid_w, 0);
        end
        // f_en held high for 10 cycles is one step
        f_en = 1'b1;
        nv   = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (valid_w) nv++;
            if (k == 0) chk("t1_hold_out", out_w, 2);
        end
        chk("t1_hold_steps", nv, 1);
        f_en = 1'b0;
        cyc();

        // clear keeps f_out and produces no pulse
        f_clr = 1'b1;
        cyc();
        f_clr = 1'b0;
        chk("clr_out_held", out_w, 2);
        chk("clr_valid",    valid_w, 0);

        // 2. free-run mode: pulses on cycles 4,8,12,16,20
        f_mode = 1'b1;
        f_en   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk("t2_valid", valid_w, ((k % 4) == 0) ? 1 : 0);
            if ((k % 4) == 0) chk("t2_out", out_w, seq2[k/4 - 1]);
        end
        f_en   = 1'b0;
        f_mode = 1'b0;
        cyc();
        f_clr = 1'b1;
        cyc();
        f_clr = 1'b0;

        // 3/4. 26 steps through overflow on both variants
        fa = 0;
        fb = 1;
        for (int i = 1; i <= 26; i++) begin
            f_en = 1'b1;
            cyc();
            if (i <= 25) begin
                chk("t3_valid_h", valid_h, 1);
                chk("t3_out_h",   out_h,   fa);
                chk("t4_out_w",   out_w,   fa);
            end else begin
                chk("t3_no_step_h", valid_h, 0);
                chk("t3_hold_out_h", out_h, 46368);
                chk("t4_wrap_out_w", out_w, 0);
            end
            chk("t4_valid_w", valid_w, 1);
            chk("t4_wrap_w",  wrap_w,  (i == 25) ? 1 : 0);
            if (i == 25) begin
                chk("t3_last_term", out_h, 46368);
                chk("t4_last_term", out_w, 46368);
            end
`ifdef FIB_INDEX_EN
            if (i == 25) chk("t4_idx_24", idx_w, 24);
            if (i == 26) chk("t4_idx_0",  idx_w, 0);
`endif
            tmp = fa + fb;
            fa  = fb;
            fb  = tmp;
            f_en = 1'b0;
            cyc();
            chk("t4_wrap_low", wrap_w, 0);
            if (i == 24) chk("t3_done_early", done_h, 0);
            if (i >= 25) chk("t3_done", done_h, 1);
        end
        f_clr = 1'b1;
        cyc();
        f_clr = 1'b0;
        chk("t3_clr_done", done_h, 0);
        f_en = 1'b1;
        cyc();
        chk("t3_restart_valid", valid_h, 1);
        chk("t3_restart_out",   out_h,   0);
        chk("t3_restart_done",  done_h,  0);
        f_en = 1'b0;
        cyc();

        // 5. asynchronous reset in the middle of free-run
        f_mode = 1'b1;
        f_en   = 1'b1;
        for (int k = 1; k <= 8; k++) cyc();
        chk("t5_pre_valid", valid_w, 1);
        chk("t5_pre_out",   out_w,   1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_out",   out_w,   0);
        chk("t5_async_valid", valid_w, 0);
        f_mode = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_no_step", valid_w, 0);
        end
        f_en = 1'b0;
        cyc();
        f_en = 1'b1;
        cyc();
        chk("t5_rise_valid", valid_w, 1);
        chk("t5_rise_out",   out_w,   0);
        f_en = 1'b0;
        cyc();
        f_en = 1'b1;
        cyc();
        chk("t5_second_out", out_w, 1);
        f_en = 1'b0;
        cyc();

        // 6. clear and rise together: clear wins
        f_clr = 1'b1;
        f_en  = 1'b1;
        cyc();
        chk("t6_no_valid", valid_w, 0);
        f_clr = 1'b0;
        f_en  = 1'b0;
        cyc();
        f_en = 1'b1;
        cyc();
        chk("t6_valid", valid_w, 1);
        chk("t6_out",   out_w,   0);
        f_en = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
